rv32i_hazard_ctrl: RTL
======================

RV32I_HAZARD_CTRL -- requirements
Module: rv32i_hazard_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn_i, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port dec_valid_i, input, 1: decode stage holds a real instruction.
REQ-004 SHALL have port dec_rs1_i, input, 5: decode rs1 address.
REQ-005 SHALL have port dec_rs2_i, input, 5: decode rs2 address.
REQ-006 SHALL have port dec_use_rs1_i, input, 1: decode instruction reads rs1.
REQ-007 SHALL have port dec_use_rs2_i, input, 1: decode instruction reads rs2.
REQ-008 SHALL have port dec_rd_i, input, 5: decode destination register.
REQ-009 SHALL have port dec_we_i, input, 1: decode instruction writes rd.
REQ-010 SHALL have port dec_load_i, input, 1: decode instruction is a load.
REQ-011 SHALL have port redirect_i, input, 1: taken branch, JAL or JALR resolved this cycle.
REQ-012 SHALL have port stall_o, output, 1: hold PC and decode registers.
REQ-013 SHALL have port fetch_nop_o, output, 1: replace fetched word with NOP (0x00000013).
REQ-014 SHALL have port dec_nop_o, output, 1: inject bubble into exec stage.
REQ-015 SHALL have port rs1_byp_o, output, 1: ALU op1 takes exec-stage ALU result.
REQ-016 SHALL have port wb_rd_o, output, 5: register file write address.
REQ-017 SHALL have port wb_we_o, output, 1: register file write enable.

Function
REQ-018 SHALL keep a tracking entry per stage EX, MEM, WB: {valid, we, rd, load}; entries shift EX->MEM->WB every cycle.
REQ-019 EX entry SHALL load decode fields when dec_valid_i=1 and stall_o=0 and redirect_i=0; otherwise it SHALL load valid=0.
REQ-020 A stage "matches" rsN when valid=1, we=1, rd!=0, rd==dec_rsN_i and dec_use_rsN_i=1; rd=x0 never matches.
REQ-021 stall_o SHALL be combinational: 1 when dec_valid_i=1, redirect_i=0, and any stage matches rs1 or rs2, except the case in REQ-022.
REQ-022 An rs1 match only in EX with EX load=0 SHALL raise rs1_byp_o=1 without stall when the bypass feature is enabled.
REQ-023 rs2 matches in any stage and load matches in EX SHALL always stall; no rs2 bypass exists.
REQ-024 The register file is not write-through; a WB match SHALL stall.
REQ-025 dec_nop_o SHALL equal stall_o OR redirect_i.
REQ-026 On redirect_i=1, a 2-bit flush counter SHALL load 1; fetch_nop_o SHALL equal redirect_i OR (counter!=0); counter decrements to 0.
REQ-027 redirect_i and hazard in the same cycle: redirect wins, stall_o=0, rs1_byp_o=0.
REQ-028 rs1_byp_o SHALL be 0 whenever stall_o=1 or dec_valid_i=0.
REQ-029 wb_rd_o and wb_we_o SHALL be driven from the WB entry; wb_we_o = valid AND we AND (rd!=0).

Reset
REQ-030 On resetn_i=0, all entries SHALL clear to valid=0 and the flush counter to 0, immediately and asynchronously.
REQ-031 During reset, stall_o, fetch_nop_o, dec_nop_o, rs1_byp_o, wb_we_o SHALL be 0 and wb_rd_o SHALL be 0.
REQ-032 Reset asserted mid-stall SHALL abandon the stall; the first cycle after release SHALL show no hazard.

Configuration
REQ-033 Macro HAZARD_BYPASS_EN SHALL control REQ-022: defined -> EX rs1 forwarding active; undefined -> rs1_byp_o tied 0 and every rs1 match stalls.

Verification
REQ-034 addi x5,x0,1 then add x6,x5,x0 -> with HAZARD_BYPASS_EN: rs1_byp_o=1 one cycle, 0 stall cycles; without: stall_o=1 for 3 cycles.
REQ-035 lw x5,0(x0) then add x6,x5,x0 -> stall_o=1 for 3 cycles in both configurations, rs1_byp_o=0.
REQ-036 addi x0,x0,7 then add x6,x0,x0 -> stall_o=0, rs1_byp_o=0, wb_we_o=0 when the addi reaches WB.
REQ-037 redirect_i pulse of 1 cycle with a pending rs2 hazard -> stall_o=0, dec_nop_o=1 for 1 cycle, fetch_nop_o=1 for 2 cycles.
REQ-038 resetn_i low during cycle 2 of a 3-cycle stall -> all outputs 0 at once; after release, the same decode inputs with empty tracking give stall_o=0.

Source files
------------

// File: rtl/rv32i_hazard_ctrl.sv
// RV32I 5-stage hazard controller: EX/MEM/WB destination tracking, interlock, flush and optional EX->op1 forwarding.
// Optional feature macro: HAZARD_BYPASS_EN enables forwarding of the EX-stage ALU result to rs1.
module rv32i_hazard_ctrl (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       dec_valid_i,
  input  logic [4:0] dec_rs1_i,
  input  logic [4:0] dec_rs2_i,
  input  logic       dec_use_rs1_i,
  input  logic       dec_use_rs2_i,
  input  logic [4:0] dec_rd_i,
  input  logic       dec_we_i,
  input  logic       dec_load_i,
  input  logic       redirect_i,
  output logic       stall_o,
  output logic       fetch_nop_o,
  output logic       dec_nop_o,
  output logic       rs1_byp_o,
  output logic [4:0] wb_rd_o,
  output logic       wb_we_o
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned NSTG  = 3;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [REG_W-1:0] rd;
    logic             load;
  } trk_t;

  trk_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [NSTG-1:0]  rs1_hit, rs2_hit;
  logic             byp_ok, hazard, active, stall_int, byp_int;
  logic             unused_load;

  function automatic logic stage_match(input trk_t e, input logic [REG_W-1:0] rs, input logic use_rs);
    return e.valid & e.we & (e.rd != '0) & (e.rd == rs) & use_rs;
  endfunction

  // Hazard detection: index 0 = EX, 1 = MEM, 2 = WB
  always_comb begin
    rs1_hit = {stage_match(wb_q, dec_rs1_i, dec_use_rs1_i),
               stage_match(mem_q, dec_rs1_i, dec_use_rs1_i),
               stage_match(ex_q, dec_rs1_i, dec_use_rs1_i)};
    rs2_hit = {stage_match(wb_q, dec_rs2_i, dec_use_rs2_i),
               stage_match(mem_q, dec_rs2_i, dec_use_rs2_i),
               stage_match(ex_q, dec_rs2_i, dec_use_rs2_i)};
`ifdef HAZARD_BYPASS_EN
    byp_ok = (rs1_hit == 3'b001) & ~ex_q.load;
`else
    byp_ok = 1'b0;
`endif
    hazard    = ((|rs1_hit) & ~byp_ok) | (|rs2_hit);
    active    = dec_valid_i & ~redirect_i;
    stall_int = active & hazard;
    byp_int   = active & ~hazard & byp_ok;
  end

  // Tracking shift and flush counter next state
  always_comb begin
    ex_d    = '0;
    mem_d   = ex_q;
    wb_d    = mem_q;
    flush_d = flush_q;
    if (dec_valid_i && !stall_int && !redirect_i) begin
      ex_d.valid = 1'b1;
      ex_d.we    = dec_we_i;
      ex_d.rd    = dec_rd_i;
      ex_d.load  = dec_load_i;
    end
    if (redirect_i) begin
      flush_d = CNT_W'(1);
    end else if (flush_q != '0) begin
      flush_d = flush_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      flush_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      flush_q <= flush_d;
    end
  end

  // Redirect-driven outputs are masked so reset forces every output low
  assign stall_o     = stall_int;
  assign rs1_byp_o   = byp_int;
  assign dec_nop_o   = resetn_i & (stall_int | redirect_i);
  assign fetch_nop_o = resetn_i & (redirect_i | (flush_q != '0));
  assign wb_rd_o     = wb_q.rd;
  assign wb_we_o     = wb_q.valid & wb_q.we & (wb_q.rd != '0);

  // Load flag only matters while the entry sits in EX
  assign unused_load = ^{ex_q.load, mem_q.load, wb_q.load};

endmodule
